// File: rtl/uart_transmitter_if.sv
// rtl/uart_transmitter_if.sv - write/status bundle between a host and uart_transmitter
interface uart_transmitter_if;
  logic [7:0] Tx_DATA;
  logic [2:0] baud_select;
  logic       Tx_EN;
  logic       Tx_WR;
  logic       TxD;
  logic       Tx_BUSY;
  logic       Tx_DONE;

  modport master (output Tx_DATA, baud_select, Tx_EN, Tx_WR,
                  input  TxD, Tx_BUSY, Tx_DONE);
  modport slave  (input  Tx_DATA, baud_select, Tx_EN, Tx_WR,
                  output TxD, Tx_BUSY, Tx_DONE);
endinterface

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8E1 UART transmitter, 16*D clocks per bit, registered TxD
module uart_transmitter (
  input  logic              clk,
  input  logic              reset,
  uart_transmitter_if.slave tx
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Clocks per frame bit (16 * divisor) for each rate code.
  function automatic logic [17:0] bit_cycles(input logic [2:0] code);
    case (code)
      3'b000:  bit_cycles = 18'd166672;
      3'b001:  bit_cycles = 18'd41664;
      3'b010:  bit_cycles = 18'd10416;
      3'b011:  bit_cycles = 18'd5216;
      3'b100:  bit_cycles = 18'd2608;
      3'b101:  bit_cycles = 18'd1296;
      3'b110:  bit_cycles = 18'd864;
      default: bit_cycles = 18'd448;
    endcase
  endfunction

  logic [2:0]  state_q, state_d;
  logic [17:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic [2:0]  baud_q, baud_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic       accept;
  logic       bit_end;
  logic [2:0] idx_inc;

  assign accept  = tx.Tx_WR & tx.Tx_EN & ~busy_q;
  assign bit_end = (cnt_q == 18'd0);
  assign idx_inc = idx_q + 3'd1;

  // cnt_q counts down to zero within a bit; every boundary reloads it from the latched rate.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    baud_d  = baud_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE) begin
      txd_d  = 1'b1;
      busy_d = 1'b0;
      if (accept) begin
        data_d  = tx.Tx_DATA;
        baud_d  = tx.baud_select;
        cnt_d   = bit_cycles(tx.baud_select) - 18'd1;
        idx_d   = 3'd0;
        state_d = S_START;
        txd_d   = 1'b0;
        busy_d  = 1'b1;
      end
    end else if (!bit_end) begin
      cnt_d = cnt_q - 18'd1;
    end else begin
      cnt_d = bit_cycles(baud_q) - 18'd1;
      case (state_q)
        S_START: begin
          state_d = S_DATA;
          idx_d   = 3'd0;
          txd_d   = data_q[0];
        end
        S_DATA: begin
          if (idx_q == 3'd7) begin
            state_d = S_PARITY;
            txd_d   = ^data_q;
          end else begin
            idx_d = idx_inc;
            txd_d = data_q[idx_inc];
          end
        end
        S_PARITY: begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          txd_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = 18'd0;
          idx_d   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 18'd0;
      idx_q   <= 3'd0;
      data_q  <= 8'd0;
      baud_q  <= 3'd0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      baud_q  <= baud_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx.TxD     = txd_q;
  assign tx.Tx_BUSY = busy_q;
  assign tx.Tx_DONE = done_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - self-checking bench for uart_transmitter
module tb_uart_transmitter;
  logic clk = 1'b0;
  logic reset;
  uart_transmitter_if ifc ();

  uart_transmitter dut (
    .clk   (clk),
    .reset (reset),
    .tx    (ifc)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [2:0]  baud;
    logic [10:0] bits;
  } vec_t;

  vec_t vec [4];
  int   divisor [8] = '{10417, 2604, 651, 326, 163, 81, 54, 28};
  int   tests = 0;
  int   fails = 0;
  int   n;
  int   w;
  int   lim;
  int   len;
  logic [7:0] rb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: start, data LSB first, even parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i + 1] = b[i];
    f[9]  = ^b;
    f[10] = 1'b1;
    return f;
  endfunction

  // Called on a negedge; returns on the first negedge after the accepting edge.
  task automatic start_write(input logic [7:0] b, input logic [2:0] c);
    ifc.Tx_DATA     = b;
    ifc.baud_select = c;
    ifc.Tx_EN       = 1'b1;
    ifc.Tx_WR       = 1'b1;
    @(negedge clk);
    ifc.Tx_WR = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [10:0] bits, input int blen,
                             input bit disturb);
    int   total;
    int   bad_txd, bad_busy, bad_done;
    int   first_txd, first_busy, first_done;
    logic e_txd, e_busy, e_done;
    total = 11 * blen;
    bad_txd = 0; bad_busy = 0; bad_done = 0;
    first_txd = -1; first_busy = -1; first_done = -1;
    for (int t = 0; t <= total; t++) begin
      e_txd  = (t < total) ? bits[t / blen] : 1'b1;
      e_busy = (t < total);
      e_done = (t == total);
      if (ifc.TxD !== e_txd) begin
        if (bad_txd == 0) first_txd = t;
        bad_txd++;
      end
      if (ifc.Tx_BUSY !== e_busy) begin
        if (bad_busy == 0) first_busy = t;
        bad_busy++;
      end
      if (ifc.Tx_DONE !== e_done) begin
        if (bad_done == 0) first_done = t;
        bad_done++;
      end
      if (t < total) begin
        if (disturb) begin
          ifc.Tx_WR       = 1'($urandom_range(0, 1));
          ifc.Tx_EN       = 1'($urandom_range(0, 1));
          ifc.Tx_DATA     = 8'($urandom);
          ifc.baud_select = 3'($urandom);
        end
        @(negedge clk);
      end
    end
    ifc.Tx_WR = 1'b0;
    chk($sformatf("%s TxD bad cycles (first %0d)", name, first_txd), bad_txd, 0);
    chk($sformatf("%s Tx_BUSY bad cycles (first %0d)", name, first_busy), bad_busy, 0);
    chk($sformatf("%s Tx_DONE bad cycles (first %0d)", name, first_done), bad_done, 0);
  endtask

  initial begin
    #(98000 * 20);
    $display("FAIL watchdog: cycle budget exhausted, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec[0] = '{8'hA1, 3'b111, 11'b11101000010};
    vec[1] = '{8'h00, 3'b111, 11'b10000000000};
    vec[2] = '{8'hFF, 3'b111, 11'b10111111110};
    vec[3] = '{8'h55, 3'b111, 11'b10010101010};

    reset = 1'b0;
    ifc.Tx_DATA = 8'h00; ifc.baud_select = 3'b000; ifc.Tx_EN = 1'b0; ifc.Tx_WR = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset TxD", ifc.TxD, 1);
    chk("reset Tx_BUSY", ifc.Tx_BUSY, 0);
    chk("reset Tx_DONE", ifc.Tx_DONE, 0);
    reset = 1'b1;
    @(negedge clk);

    ifc.Tx_DATA = 8'h3C; ifc.baud_select = 3'b111; ifc.Tx_EN = 1'b0; ifc.Tx_WR = 1'b1;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (ifc.TxD !== 1'b1 || ifc.Tx_BUSY !== 1'b0) n++;
    end
    chk("write with Tx_EN=0 ignored", n, 0);
    ifc.Tx_WR = 1'b0;

    for (int i = 0; i < 4; i++) begin
      start_write(vec[i].data, vec[i].baud);
      check_frame($sformatf("table %0d", i), vec[i].bits, 16 * divisor[vec[i].baud], 1'b0);
      @(negedge clk);
      chk($sformatf("table %0d Tx_DONE one cycle", i), ifc.Tx_DONE, 0);
    end

    start_write(8'hC3, 3'b111);
    ifc.Tx_DATA = 8'h3C;
    ifc.Tx_WR   = 1'b1;
    check_frame("busy write ignored", frame_of(8'hC3), 448, 1'b0);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (ifc.TxD !== 1'b1 || ifc.Tx_BUSY !== 1'b0) n++;
    end
    chk("no frame after busy write", n, 0);

    rb = 8'($urandom);
    start_write(rb, 3'b111);
    check_frame($sformatf("random %02h disturbed", rb), frame_of(rb), 448, 1'b1);
    @(negedge clk);

    start_write(8'hA1, 3'b111);
    repeat (4 * 448 + 100) @(negedge clk);
    chk("A1 D3 level", ifc.TxD, 0);
    reset = 1'b0;
    #1;
    chk("mid-frame reset TxD", ifc.TxD, 1);
    chk("mid-frame reset Tx_BUSY", ifc.Tx_BUSY, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    start_write(8'h0F, 3'b111);
    check_frame("after reset 0F", 11'b10000011110, 448, 1'b0);
    @(negedge clk);

    start_write(8'h01, 3'b110);
    check_frame("b2b first 01", 11'b11000000010, 864, 1'b0);
    start_write(8'h80, 3'b110);
    check_frame("b2b second 80", 11'b11100000000, 864, 1'b0);
    @(negedge clk);

    for (int c = 0; c < 8; c++) begin
      len = 16 * divisor[c];
      lim = (c < 2) ? 2000 : len + 4;
      w   = 0;
      start_write(8'hFF, 3'(c));
      while (ifc.TxD === 1'b0 && w < lim) begin
        w++;
        @(negedge clk);
      end
      chk($sformatf("start width code %0d", c), w, (c < 2) ? 2000 : len);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
